// File: rtl/countdown_timer.sv
// Down-counting interval timer with pause/resume, one-shot expiry and optional auto-reload.
// Input priority per edge is reset > load > stop > start; every output is registered.
module countdown_timer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  paused,
    output logic                  expired,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] count_reg, count_next;
    logic [DATA_WIDTH-1:0] reload_reg, reload_next;
    logic                  done_reg, done_next;
    logic                  running_reg, paused_reg, expired_reg;
    logic                  step;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;
        step        = 1'b0;

        if (load) begin
            count_next  = load_value;
            reload_next = load_value;
            state_next  = IDLE;
        end else if (stop) begin
            // stop masks start on the same edge, even where it has no effect itself
            if (state_reg == RUN)
                state_next = PAUSED;
        end else if (state_reg == RUN) begin
            step = 1'b1;
        end else if (start && (state_reg == IDLE || state_reg == PAUSED) && count_reg != '0) begin
            step = 1'b1;
        end

        // count is never 0 while stepping, so 1 is the only terminal value
        if (step) begin
            if (count_reg != ONE) begin
                count_next = count_reg - ONE;
                state_next = RUN;
            end else begin
                done_next = 1'b1;
                if (auto_reload) begin
                    count_next = reload_reg;
                    state_next = RUN;
                end else begin
                    count_next = '0;
                    state_next = EXPIRED;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            reload_reg  <= '0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
            paused_reg  <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            reload_reg  <= reload_next;
            done_reg    <= done_next;
            running_reg <= (state_next == RUN);
            paused_reg  <= (state_next == PAUSED);
            expired_reg <= (state_next == EXPIRED);
        end
    end

    assign count   = count_reg;
    assign running = running_reg;
    assign paused  = paused_reg;
    assign expired = expired_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer: each task queues stimulus with hand-derived expected
// outputs, drives one edge per entry and compares the DUT against the popped expectation.
module tb_countdown_timer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] load_value = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          auto_reload = 1'b0;
    logic [DW-1:0] count;
    logic          running, paused, expired, done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic          rst;
        logic          ld;
        logic [DW-1:0] lv;
        logic          st;
        logic          sp;
        logic          ar;
    } stim_t;

    // Packed as {count, running, paused, expired, done}
    typedef struct packed {
        logic [DW-1:0] cnt;
        logic          run;
        logic          pau;
        logic          exp;
        logic          dn;
    } obs_t;

    obs_t exp_q[$];

    countdown_timer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .count      (count),
        .running    (running),
        .paused     (paused),
        .expired    (expired),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(logic rst, logic ld, logic [DW-1:0] lv, logic st, logic sp, logic ar);
        S = '{rst: rst, ld: ld, lv: lv, st: st, sp: sp, ar: ar};
    endfunction

    function automatic obs_t E(logic [DW-1:0] cnt, logic run, logic pau, logic ex, logic dn);
        E = '{cnt: cnt, run: run, pau: pau, exp: ex, dn: dn};
    endfunction

    function automatic obs_t sample();
        sample = '{cnt: count, run: running, pau: paused, exp: expired, dn: done};
    endfunction

    // Queue the expectation, present inputs for one rising edge, then settle past the edge.
    task automatic drive(input stim_t s, input obs_t e);
        exp_q.push_back(e);
        reset       = s.rst;
        load        = s.ld;
        load_value  = s.lv;
        start       = s.st;
        stop        = s.sp;
        auto_reload = s.ar;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(S(1, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 0, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 0, 0));
        s.push_back(S(0, 1, 5, 0, 0, 0));  e.push_back(E(5, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(4, 1, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(3, 1, 0, 0, 0));
        s.push_back(S(1, 0, 0, 1, 0, 0));  e.push_back(E(0, 0, 0, 0, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 0, 0));
        end
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_oneshot();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(S(0, 1, 5, 0, 0, 0));  e.push_back(E(5, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(4, 1, 0, 0, 0));
        for (int c = 3; c >= 1; c--) begin
            s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(DW'(c), 1, 0, 0, 0));
        end
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 1, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 1, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(0, 0, 0, 1, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(0, 0, 0, 1, 0));
        s.push_back(S(0, 0, 0, 0, 1, 0));  e.push_back(E(0, 0, 0, 1, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL oneshot[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_pause_resume();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(S(0, 1, 10, 0, 0, 0)); e.push_back(E(10, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(9, 1, 0, 0, 0));   // run edge 1
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(8, 1, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(7, 1, 0, 0, 0));   // run edge 3
        s.push_back(S(0, 0, 0, 0, 1, 0));  e.push_back(E(7, 0, 1, 0, 0));
        for (int h = 0; h < 4; h++) begin
            s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(7, 0, 1, 0, 0));
        end
        s.push_back(S(0, 0, 0, 1, 1, 0));  e.push_back(E(7, 0, 1, 0, 0));   // stop beats start
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(6, 1, 0, 0, 0));   // run edge 4
        for (int c = 5; c >= 1; c--) begin
            s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(DW'(c), 1, 0, 0, 0));
        end
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 1, 1));   // run edge 10
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 1, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL pause_resume[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_auto_reload();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(S(0, 1, 3, 0, 0, 1));  e.push_back(E(3, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 1));  e.push_back(E(2, 1, 0, 0, 0));
        for (int p = 0; p < 3; p++) begin
            s.push_back(S(0, 0, 0, 0, 0, 1));  e.push_back(E(1, 1, 0, 0, 0));
            s.push_back(S(0, 0, 0, 0, 0, 1));  e.push_back(E(3, 1, 0, 0, 1));
            s.push_back(S(0, 0, 0, 0, 0, 1));  e.push_back(E(2, 1, 0, 0, 0));
        end
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(1, 1, 0, 0, 0));   // auto cleared mid-period
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 1, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(0, 0, 0, 1, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL auto_reload[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_edge_values();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(S(0, 1, 1, 0, 0, 0));       e.push_back(E(1, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));       e.push_back(E(0, 0, 0, 1, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0));       e.push_back(E(0, 0, 0, 1, 0));
        s.push_back(S(0, 1, 0, 0, 0, 0));       e.push_back(E(0, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));       e.push_back(E(0, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0));       e.push_back(E(0, 0, 0, 0, 0));
        s.push_back(S(0, 1, 16'hFFFF, 0, 0, 0)); e.push_back(E(16'hFFFF, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));       e.push_back(E(16'hFFFE, 1, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0));       e.push_back(E(16'hFFFD, 1, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 1, 0));       e.push_back(E(16'hFFFD, 0, 1, 0, 0));
        s.push_back(S(0, 0, 0, 0, 1, 0));       e.push_back(E(16'hFFFD, 0, 1, 0, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL edge_values[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_collisions();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(S(0, 1, 2, 0, 0, 0));  e.push_back(E(2, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(1, 1, 0, 0, 0));
        s.push_back(S(0, 1, 8, 0, 0, 0));  e.push_back(E(8, 0, 0, 0, 0));   // load on terminal edge
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(8, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(7, 1, 0, 0, 0));
        s.push_back(S(0, 1, 1, 1, 1, 0));  e.push_back(E(1, 0, 0, 0, 0));   // load beats stop+start
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(0, 0, 0, 1, 1));
        s.push_back(S(0, 1, 9, 0, 0, 0));  e.push_back(E(9, 0, 0, 0, 0));   // load clears EXPIRED
        s.push_back(S(0, 0, 0, 0, 0, 0));  e.push_back(E(9, 0, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL collisions[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        // Reload value 1 in auto mode: every edge is a terminal step.
        s.push_back(S(0, 1, 1, 0, 0, 1));  e.push_back(E(1, 0, 0, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 1));  e.push_back(E(1, 1, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            s.push_back(S(0, 0, 0, 0, 0, 1));  e.push_back(E(1, 1, 0, 0, 1));
        end
        s.push_back(S(0, 0, 0, 0, 1, 1));  e.push_back(E(1, 0, 1, 0, 0));
        s.push_back(S(0, 0, 0, 1, 0, 0));  e.push_back(E(0, 0, 0, 1, 1));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            got = sample();
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got {cnt,run,pau,exp,done}=%h required %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_pause_resume();
        test_auto_reload();
        test_edge_values();
        test_collisions();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
